// File: rtl/dlx_pkg.sv
// -----------------------------------------------------------------------------
// dlx_pkg -- shared constants and helpers for the DLX decode stage.
//
// Contents:
//   DATA_W / REG_AW / NUM_REGS / OP_W : datapath and register-file widths
//   OP_*                              : opcodes decoded by id_stage
//   NOP / LINK_REG                    : bubble instruction, JAL link register
//   ifid_t                            : IF/ID pipeline register contents
//   instr_class_e / classify()        : instruction format classification
//   sext16() / sext26()               : immediate sign extension
// -----------------------------------------------------------------------------
package dlx_pkg;

   localparam int DATA_W   = 32;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;
   localparam int OP_W     = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQZ  = 6'h04;
   localparam logic [OP_W-1:0] OP_BNEZ  = 6'h05;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;

   localparam logic [DATA_W-1:0] NOP      = 32'h0000_0000;
   localparam logic [REG_AW-1:0] LINK_REG = 5'd31;

   typedef struct packed {
      logic [DATA_W-1:0] pc_4;
      logic [DATA_W-1:0] instr;
      logic              valid;
   } ifid_t;

   // Format decides which fields are register sources and how the
   // immediate is formed.
   typedef enum logic [1:0] {
      CLS_R = 2'd0,
      CLS_I = 2'd1,
      CLS_J = 2'd2
   } instr_class_e;

   function automatic instr_class_e classify(input logic [OP_W-1:0] op);
      instr_class_e cls;
      case (op)
         OP_RTYPE:      cls = CLS_R;
         OP_J, OP_JAL:  cls = CLS_J;
         default:       cls = CLS_I;
      endcase
      return cls;
   endfunction

   function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   function automatic logic [DATA_W-1:0] sext26(input logic [25:0] v);
      return {{6{v[25]}}, v};
   endfunction

endpackage : dlx_pkg

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file -- 32 x 32 DLX general-purpose register file.
//
// Two combinational read ports, one synchronous write port. r0 always reads
// zero and ignores writes. Synchronous active-high reset clears every entry.
//
// Build option: define WB_BYPASS_EN to forward the write data to a read port
// addressing the register being written in the same cycle.
//
// Ports:
//   clk_i     in   1   rising-edge clock
//   rst_i     in   1   synchronous active-high reset
//   we_i      in   1   write enable
//   waddr_i   in   5   write address
//   wdata_i   in   32  write data
//   raddr1_i  in   5   read port 1 address
//   raddr2_i  in   5   read port 2 address
//   rdata1_o  out  32  read port 1 data
//   rdata2_o  out  32  read port 2 data
// -----------------------------------------------------------------------------
module reg_file
   import dlx_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] raddr1_i,
   input  logic [REG_AW-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
      rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
`ifdef WB_BYPASS_EN
      // Same-cycle write wins over the stored value; r0 is never forwarded.
      if (we_i && (waddr_i != '0) && (waddr_i == raddr1_i)) begin
         rdata1_o = wdata_i;
      end
      if (we_i && (waddr_i != '0) && (waddr_i == raddr2_i)) begin
         rdata2_o = wdata_i;
      end
`endif
   end

endmodule : reg_file

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- DLX instruction-decode stage.
//
// Holds the IF/ID pipeline register, decodes the instruction combinationally,
// reads operands from the register file, detects load-use (and, without the
// writeback bypass, write/read) hazards, and resolves branches and jumps.
//
// Build option: WB_BYPASS_EN
//   defined   : a source register written by writeback this cycle reads the
//               new value through the register-file bypass.
//   undefined : such a read stalls the stage for one cycle until the write
//               has landed.
//
// Ports:
//   clk             in   1   rising-edge clock
//   reset           in   1   synchronous active-high reset
//   add_pc_4_in     in   32  PC+4 from fetch
//   instruction_in  in   32  fetched instruction
//   wb_reg_write    in   1   writeback enable
//   wb_rd           in   5   writeback register
//   wb_data         in   32  writeback data
//   ex_mem_read     in   1   instruction in EX is a load
//   ex_rd           in   5   destination of the instruction in EX
//   add_out         out  32  branch/jump target
//   mux_pcsrc_out   out  1   1 = fetch from add_out, 0 = PC+4
//   pc_write_en     out  1   PC and IF/ID load enable (0 = stall)
//   id_valid        out  1   decoded instruction valid (0 = bubble)
//   id_opcode       out  6   opcode field
//   id_rs1/2        out  5   source register fields
//   id_rd           out  5   destination register (31 for JAL)
//   id_pc_4         out  32  PC+4 of the decoded instruction
//   id_rs1/2_data   out  32  source operands
//   id_imm          out  32  sign-extended immediate
// -----------------------------------------------------------------------------
module id_stage
   import dlx_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] add_pc_4_in,
   input  logic [DATA_W-1:0] instruction_in,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] add_out,
   output logic              mux_pcsrc_out,
   output logic              pc_write_en,
   output logic              id_valid,
   output logic [OP_W-1:0]   id_opcode,
   output logic [REG_AW-1:0] id_rs1,
   output logic [REG_AW-1:0] id_rs2,
   output logic [REG_AW-1:0] id_rd,
   output logic [DATA_W-1:0] id_pc_4,
   output logic [DATA_W-1:0] id_rs1_data,
   output logic [DATA_W-1:0] id_rs2_data,
   output logic [DATA_W-1:0] id_imm
);

   ifid_t ifid_q, ifid_d;

   instr_class_e      cls;
   logic [OP_W-1:0]   opcode;
   logic [REG_AW-1:0] rs1, rs2, rd_r;
   logic              uses_rs1, uses_rs2;
   logic              load_hazard, wb_hazard, stall;
   logic              cond_taken, taken;
   logic [DATA_W-1:0] rs1_data, rs2_data;
   logic [DATA_W-1:0] imm;

   // ---------------------------------------------------------------- IF/ID
   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_q <= '{pc_4: '0, instr: NOP, valid: 1'b0};
      end else begin
         ifid_q <= ifid_d;
      end
   end

   always_comb begin
      ifid_d = ifid_q;
      if (stall) begin
         ifid_d = ifid_q;
      end else if (taken) begin
         // The fall-through instruction fetched behind a taken transfer is
         // squashed; its PC+4 is kept only as a don't-care payload.
         ifid_d = '{pc_4: add_pc_4_in, instr: NOP, valid: 1'b0};
      end else begin
         ifid_d = '{pc_4: add_pc_4_in, instr: instruction_in, valid: 1'b1};
      end
   end

   // ---------------------------------------------------------------- decode
   assign opcode = ifid_q.instr[31:26];
   assign rs1    = ifid_q.instr[25:21];
   assign rs2    = ifid_q.instr[20:16];
   assign rd_r   = ifid_q.instr[15:11];
   assign cls    = classify(opcode);

   // J/JAL read no register; I-type reads rs1 only; R-type reads both.
   assign uses_rs1 = (cls != CLS_J);
   assign uses_rs2 = (cls == CLS_R);

   reg_file u_reg_file (
      .clk_i    (clk),
      .rst_i    (reset),
      .we_i     (wb_reg_write),
      .waddr_i  (wb_rd),
      .wdata_i  (wb_data),
      .raddr1_i (rs1),
      .raddr2_i (rs2),
      .rdata1_o (rs1_data),
      .rdata2_o (rs2_data)
   );

   assign load_hazard = ex_mem_read && (ex_rd != '0) &&
                        ((uses_rs1 && (ex_rd == rs1)) ||
                         (uses_rs2 && (ex_rd == rs2)));

`ifdef WB_BYPASS_EN
   assign wb_hazard = 1'b0;
`else
   // Without forwarding the register file would hand back the stale value,
   // so hold the instruction one cycle until the write has landed.
   assign wb_hazard = wb_reg_write && (wb_rd != '0) &&
                      ((uses_rs1 && (wb_rd == rs1)) ||
                       (uses_rs2 && (wb_rd == rs2)));
`endif

   // A bubble in IF/ID has nothing to protect, so it never stalls.
   assign stall = ifid_q.valid && (load_hazard || wb_hazard);

   always_comb begin
      case (opcode)
         OP_BEQZ:      cond_taken = (rs1_data == '0);
         OP_BNEZ:      cond_taken = (rs1_data != '0);
         OP_J, OP_JAL: cond_taken = 1'b1;
         default:      cond_taken = 1'b0;
      endcase
   end

   assign taken = ifid_q.valid && !stall && cond_taken;

   always_comb begin
      case (opcode)
         OP_RTYPE:              id_rd = rd_r;
         OP_JAL:                id_rd = LINK_REG;
         OP_J, OP_BEQZ, OP_BNEZ: id_rd = '0;
         default:               id_rd = rs2;
      endcase
   end

   assign imm = (cls == CLS_J) ? sext26(ifid_q.instr[25:0])
                               : sext16(ifid_q.instr[15:0]);

   assign add_out       = ifid_q.pc_4 + imm;
   assign mux_pcsrc_out = taken;
   assign pc_write_en   = reset || !stall;
   assign id_valid      = ifid_q.valid && !stall;
   assign id_opcode     = opcode;
   assign id_rs1        = rs1;
   assign id_rs2        = rs2;
   assign id_pc_4       = ifid_q.pc_4;
   assign id_rs1_data   = rs1_data;
   assign id_rs2_data   = rs2_data;
   assign id_imm        = imm;

endmodule : id_stage

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- directed-vector bench for id_stage.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge (or 1 ns after a mid-cycle input change).
// -----------------------------------------------------------------------------
module tb_id_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] add_pc_4_in, instruction_in;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic [31:0] add_out;
   logic        mux_pcsrc_out, pc_write_en, id_valid;
   logic [5:0]  id_opcode;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_pc_4, id_rs1_data, id_rs2_data, id_imm;

   int n_vec = 0;
   int n_err = 0;

   id_stage dut (
      .clk            (clk),
      .reset          (reset),
      .add_pc_4_in    (add_pc_4_in),
      .instruction_in (instruction_in),
      .wb_reg_write   (wb_reg_write),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .ex_mem_read    (ex_mem_read),
      .ex_rd          (ex_rd),
      .add_out        (add_out),
      .mux_pcsrc_out  (mux_pcsrc_out),
      .pc_write_en    (pc_write_en),
      .id_valid       (id_valid),
      .id_opcode      (id_opcode),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_rd          (id_rd),
      .id_pc_4        (id_pc_4),
      .id_rs1_data    (id_rs1_data),
      .id_rs2_data    (id_rs2_data),
      .id_imm         (id_imm)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
      return {6'h00, s1, s2, d, 11'h000};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] d,
                                         input logic [15:0] im);
      return {op, s1, d, im};
   endfunction

   function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] off);
      return {op, off};
   endfunction

   initial begin
      reset = 1'b1; add_pc_4_in = '0; instruction_in = '0;
      wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
      ex_mem_read = 1'b0; ex_rd = '0;

      // Reset state
      tick(); tick();
      chk("rst_pcwe", 32'(pc_write_en), 32'd1);
      reset = 1'b0;
      settle();
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_pcsrc", 32'(mux_pcsrc_out), 32'd0);
      chk("rst_pc4", id_pc_4, 32'd0);

      // Write r1, read it back on both ports
      tick();
      wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0055;
      tick();
      wb_reg_write = 1'b0;
      instruction_in = rtype(5'd1, 5'd1, 5'd2); add_pc_4_in = 32'd4;
      tick();
      instruction_in = '0;
      settle();
      chk("r1_rs1", id_rs1_data, 32'h55);
      chk("r1_rs2", id_rs2_data, 32'h55);
      chk("r1_rd", 32'(id_rd), 32'd2);
      chk("r1_valid", 32'(id_valid), 32'd1);

      // Reset clears the register file
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      instruction_in = rtype(5'd1, 5'd1, 5'd2);
      tick();
      instruction_in = '0;
      settle();
      chk("rst_regs", id_rs1_data, 32'd0);

      // BEQZ r0, +8 at pc_4=100: taken, then flushed
      tick();
      instruction_in = itype(6'h04, 5'd0, 5'd0, 16'h0008); add_pc_4_in = 32'd100;
      tick();
      instruction_in = rtype(5'd0, 5'd0, 5'd9); add_pc_4_in = 32'd104;
      settle();
      chk("beqz_tgt", add_out, 32'd108);
      chk("beqz_pcsrc", 32'(mux_pcsrc_out), 32'd1);
      chk("beqz_valid", 32'(id_valid), 32'd1);
      tick();
      settle();
      chk("flush_valid", 32'(id_valid), 32'd0);
      chk("flush_op", 32'(id_opcode), 32'd0);
      chk("flush_pcsrc", 32'(mux_pcsrc_out), 32'd0);
      tick();
      settle();
      chk("post_flush_rd", 32'(id_rd), 32'd9);
      chk("post_flush_pc4", id_pc_4, 32'd104);

      // Backward branch: sign extension of imm16
      instruction_in = itype(6'h04, 5'd0, 5'd0, 16'hFFF0); add_pc_4_in = 32'h0000_1000;
      tick();
      instruction_in = '0;
      settle();
      chk("neg_tgt", add_out, 32'h0000_0FF0);
      chk("neg_imm", id_imm, 32'hFFFF_FFF0);
      tick();

      // BNEZ r1 with r1=0: not taken, next instruction loads normally
      instruction_in = itype(6'h05, 5'd1, 5'd0, 16'h0010); add_pc_4_in = 32'd200;
      tick();
      instruction_in = rtype(5'd0, 5'd0, 5'd10); add_pc_4_in = 32'd204;
      settle();
      chk("bnez_pcsrc", 32'(mux_pcsrc_out), 32'd0);
      chk("bnez_tgt", add_out, 32'd216);
      tick();
      settle();
      chk("bnez_next_valid", 32'(id_valid), 32'd1);
      chk("bnez_next_pc4", id_pc_4, 32'd204);
      chk("bnez_next_rd", 32'(id_rd), 32'd10);

      // Load-use stall on ADD r4,r3,r2
      tick();
      instruction_in = rtype(5'd3, 5'd2, 5'd4); add_pc_4_in = 32'd300;
      tick();
      instruction_in = itype(6'h08, 5'd0, 5'd6, 16'h0001); add_pc_4_in = 32'd304;
      ex_mem_read = 1'b1; ex_rd = 5'd0;
      #1 chk("exrd0_pcwe", 32'(pc_write_en), 32'd1);
      ex_rd = 5'd2;
      #1 chk("stall_rs2_pcwe", 32'(pc_write_en), 32'd0);
      ex_rd = 5'd3;
      settle();
      chk("stall_pcwe", 32'(pc_write_en), 32'd0);
      chk("stall_valid", 32'(id_valid), 32'd0);
      chk("stall_pcsrc", 32'(mux_pcsrc_out), 32'd0);
      tick();
      ex_mem_read = 1'b0; ex_rd = '0;
      settle();
      chk("held_pcwe", 32'(pc_write_en), 32'd1);
      chk("held_valid", 32'(id_valid), 32'd1);
      chk("held_rd", 32'(id_rd), 32'd4);
      chk("held_pc4", id_pc_4, 32'd300);
      tick();
      settle();
      chk("issued_next_pc4", id_pc_4, 32'd304);
      chk("issued_next_rd", 32'(id_rd), 32'd6);
      chk("issued_next_imm", id_imm, 32'd1);

      // Reset asserted while stalled
      instruction_in = rtype(5'd3, 5'd2, 5'd4); add_pc_4_in = 32'd400;
      tick();
      add_pc_4_in = 32'd404;
      ex_mem_read = 1'b1; ex_rd = 5'd3;
      reset = 1'b1;
      #1 chk("rst_stall_pcwe", 32'(pc_write_en), 32'd1);
      tick();
      reset = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
      settle();
      chk("rst_stall_valid", 32'(id_valid), 32'd0);
      chk("rst_stall_pc4", id_pc_4, 32'd0);

      // Reset asserted while a jump is flushing
      tick();
      instruction_in = jtype(6'h02, 26'h000_0010); add_pc_4_in = 32'd500;
      tick();
      instruction_in = rtype(5'd0, 5'd0, 5'd11); add_pc_4_in = 32'd504;
      settle();
      chk("j_pcsrc", 32'(mux_pcsrc_out), 32'd1);
      chk("j_tgt", add_out, 32'd516);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      chk("rst_flush_pc4", id_pc_4, 32'd0);
      chk("rst_flush_valid", 32'(id_valid), 32'd0);

      // Write r5 while reading it
      tick();
      instruction_in = itype(6'h23, 5'd5, 5'd7, 16'h0000); add_pc_4_in = 32'd600;
      tick();
      instruction_in = '0; add_pc_4_in = 32'd604;
      wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
      settle();
`ifdef WB_BYPASS_EN
      chk("byp_data", id_rs1_data, 32'hDEAD_BEEF);
      chk("byp_pcwe", 32'(pc_write_en), 32'd1);
      tick();
      wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
`else
      chk("wbst_pcwe", 32'(pc_write_en), 32'd0);
      chk("wbst_valid", 32'(id_valid), 32'd0);
      tick();
      wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
      settle();
      chk("wbst_after_pcwe", 32'(pc_write_en), 32'd1);
      chk("wbst_after_valid", 32'(id_valid), 32'd1);
      chk("wbst_after_op", 32'(id_opcode), 32'h23);
      chk("wbst_after_data", id_rs1_data, 32'hDEAD_BEEF);
      tick();
`endif

      // JAL with offset -4 at pc_4=0
      instruction_in = jtype(6'h03, 26'h3FF_FFFC); add_pc_4_in = 32'd0;
      tick();
      instruction_in = '0;
      settle();
      chk("jal_tgt", add_out, 32'hFFFF_FFFC);
      chk("jal_rd", 32'(id_rd), 32'd31);
      chk("jal_pcsrc", 32'(mux_pcsrc_out), 32'd1);
      tick();
      settle();
      chk("jal_flush_valid", 32'(id_valid), 32'd0);

      // Write r0=7 while reading r0, then read again
      instruction_in = itype(6'h23, 5'd0, 5'd8, 16'h0000);
      tick();
      instruction_in = '0;
      wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'd7;
      settle();
      chk("r0_same_cycle", id_rs1_data, 32'd0);
      chk("r0_pcwe", 32'(pc_write_en), 32'd1);
      tick();
      wb_reg_write = 1'b0; wb_data = '0;
      settle();
      chk("r0_after", id_rs1_data, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_id_stage

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high; ports `clk` and `reset`.
REQ-002 clk  input  1  rising-edge clock for IF/ID register and register file.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 add_pc_4_in  input  32  PC+4 from the fetch stage.
REQ-005 instruction_in  input  32  fetched instruction.
REQ-006 wb_reg_write, wb_rd, wb_data  input  1/5/32  writeback port.
REQ-007 ex_mem_read, ex_rd  input  1/5  load-in-EX hazard information.
REQ-008 add_out  output  32  branch/jump target to fetch PC mux.
REQ-009 mux_pcsrc_out  output  1  select target (1) or PC+4 (0).
REQ-010 pc_write_en  output  1  fetch PC and IF/ID load enable; 0 = stall.
REQ-011 id_valid, id_opcode, id_rs1, id_rs2, id_rd  output  1/6/5/5/5  decoded fields.
REQ-012 id_pc_4, id_rs1_data, id_rs2_data, id_imm  output  32 each  operands.

Function
REQ-013 The IF/ID register (pc_4, instr, valid) SHALL load when pc_write_en=1 and hold otherwise.
REQ-014 Decode outputs SHALL be combinational from the IF/ID register and register file: zero added latency after IF/ID.
REQ-015 DLX fields: opcode[31:26], rs1[25:21]; R-type (opcode 0): rs2[20:16], rd[15:11]; I-type: rd[20:16], imm = sext(instr[15:0]); JAL: id_rd=31.
REQ-016 Register r0 SHALL read 0; writes to r0 SHALL be ignored.
REQ-017 Hazard stall: ex_mem_read=1 and ex_rd!=0 and ex_rd equals a used source SHALL drive pc_write_en=0 and id_valid=0 (bubble).
REQ-018 BEQZ taken when rs1_data==0, BNEZ when !=0, J/JAL always; target = id_pc_4 + sext(imm16) for branches, + sext(instr[25:0]) for J/JAL, modulo 2^32.
REQ-019 mux_pcsrc_out SHALL be 1 only for a taken control instruction with IF/ID valid=1 and no stall that cycle.
REQ-020 Taken control SHALL flush: IF/ID loads NOP (instr 0, valid 0) on the next edge.
REQ-021 Priority: reset > stall > flush > normal load.
REQ-022 Register file write occurs on rising clk when wb_reg_write=1.

Reset
REQ-023 Reset SHALL clear IF/ID to pc_4=0, instr=NOP, valid=0; therefore id_valid=0 and mux_pcsrc_out=0.
REQ-024 Reset SHALL clear all 32 registers to 0; reset asserted mid-stall or mid-flush SHALL override both.
REQ-025 pc_write_en SHALL be 1 while in reset.

Configuration
REQ-026 WB_BYPASS_EN defined: a read of a register written in the same cycle SHALL return wb_data.
REQ-027 WB_BYPASS_EN undefined: a same-cycle write/read match (wb_rd!=0) SHALL add a one-cycle stall per REQ-017 rules.

Structure
REQ-028 Opcodes (J=02h, JAL=03h, BEQZ=04h, BNEZ=05h, LW=23h), NOP and width constants SHALL live in the shared package dlx_pkg.
REQ-029 The 32x32 register file SHALL be a sub-module reg_file (two read ports, one write port, optional bypass).

Verification
REQ-030 Reset then BEQZ r0, imm=8, pc_4=100 -> add_out=108, mux_pcsrc_out=1, next id_valid=0.
REQ-031 BNEZ r1 with r1=0 -> mux_pcsrc_out=0, no flush.
REQ-032 ex_mem_read=1, ex_rd=3, ADD r4,r3,r2 in ID -> pc_write_en=0 one cycle, id_valid=0, instruction held then issued.
REQ-033 Write r5=DEADBEEFh while reading r5 -> bypass on: data=DEADBEEFh; off: one stall, then DEADBEEFh.
REQ-034 JAL, offset=-4 (3FFFFFCh), pc_4=0 -> add_out=FFFFFFFCh, id_rd=31; write r0=7 -> r0 reads 0.
